// File: rtl/div_seq.sv
// Multi-cycle restoring divider, signed 32-bit by default: quotient on LO, remainder on HI.
// Optional macro DIV_UNSIGNED_SEL_EN adds input uns, which selects unsigned division per operation.

// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// ITER  | one restoring quotient bit per clock, WIDTH cycles
// FIX   | sign correction / divide-by-zero result, done on exit
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef DIV_UNSIGNED_SEL_EN
   input  logic             uns,
`endif
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] HI,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             sign_q;
   logic             sign_r;
   logic             dbz;

   logic             uns_sel;
   logic             accept;
   logic             b_zero;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;
   logic             take;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

`ifdef DIV_UNSIGNED_SEL_EN
   assign uns_sel = uns;
`else
   assign uns_sel = 1'b0;
`endif

   // A start landing in the done cycle is dropped; the control unit re-issues it.
   assign accept = (state == IDLE) && start && !done;
   assign b_zero = (B == '0);
   assign a_neg  = A[WIDTH-1] & ~uns_sel;
   assign b_neg  = B[WIDTH-1] & ~uns_sel;
   assign a_abs  = a_neg ? ('0 - A) : A;
   assign b_abs  = b_neg ? ('0 - B) : B;

   // rem < dvs always holds, so the extra bit of the difference is a clean borrow flag.
   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign rem_sub  = rem_sh - {1'b0, dvs};
   assign take     = ~rem_sub[WIDTH];
   assign rem_step = take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_step = {quo[WIDTH-2:0], take};

   assign q_fix = sign_q ? ('0 - quo) : quo;
   assign r_fix = sign_r ? ('0 - rem) : rem;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = b_zero ? FIX : ITER;
            end
         end
         ITER: begin
            if (cnt == '0) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
         LO          <= '0;
         HI          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  busy   <= 1'b1;
                  dbz    <= b_zero;
                  sign_q <= a_neg ^ b_neg;
                  sign_r <= a_neg;
                  rem    <= '0;
                  // On divide by zero quo just carries the raw dividend through to HI.
                  quo    <= b_zero ? A : a_abs;
                  dvs    <= b_abs;
                  cnt    <= CW'(WIDTH - 1);
               end
            end
            ITER: begin
               rem <= rem_step;
               quo <= quo_step;
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (dbz) begin
                  LO          <= '1;
                  HI          <= quo;
                  div_by_zero <= 1'b1;
               end else begin
                  LO          <= q_fix;
                  HI          <= r_fix;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
